// File: rtl/ahb_lite_copy_master_if.sv
// rtl/ahb_lite_copy_master_if.sv - AHB-Lite signal bundle between the copy engine and the bus matrix port
interface ahb_lite_copy_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_copy_master.sv
// rtl/ahb_lite_copy_master.sv - AHB-Lite word copy engine: one single read then one single write per word
module ahb_lite_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   start,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  input  logic [LEN_W-1:0]       word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            err_addr,
  ahb_lite_copy_master_if.master bus
);

  localparam logic [1:0]  TRANS_IDLE   = 2'b00;
  localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_A,
    WR_D,
    DONE,
    ERR
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      buf_q;
  logic [31:0]      wdata_q;
  logic [LEN_W-1:0] remain_q;
  logic             err_on_write_q;
  logic             last_word;

  assign last_word = (remain_q == LEN_W'(1));

  // Fixed transfer attributes: single word, privileged data access
  assign bus.HSIZE  = 3'b010;
  assign bus.HBURST = 3'b000;
  assign bus.HPROT  = 4'b0011;
  assign bus.HWDATA = wdata_q;

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and address-phase outputs; every data phase is followed by an IDLE address phase
  always_comb begin
    state_n    = state_q;
    bus.HADDR  = src_q;
    bus.HTRANS = TRANS_IDLE;
    bus.HWRITE = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = (word_count == '0) ? DONE : RD_A;
        end
      end
      RD_A: begin
        bus.HADDR  = src_q;
        bus.HTRANS = TRANS_NONSEQ;
        if (bus.HREADY) begin
          state_n = RD_D;
        end
      end
      RD_D: begin
        // HRESP in a wait cycle is the first half of a two-cycle ERROR: just wait
        if (bus.HREADY) begin
          state_n = bus.HRESP ? ERR : WR_A;
        end
      end
      WR_A: begin
        bus.HADDR  = dst_q;
        bus.HTRANS = TRANS_NONSEQ;
        bus.HWRITE = 1'b1;
        if (bus.HREADY) begin
          state_n = WR_D;
        end
      end
      WR_D: begin
        bus.HADDR = dst_q;
        if (bus.HREADY) begin
          if (bus.HRESP) begin
            state_n = ERR;
          end else begin
            state_n = last_word ? DONE : RD_A;
          end
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Job registers: addresses, remaining count, read buffer and write-data hold register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src_q          <= '0;
      dst_q          <= '0;
      remain_q       <= '0;
      buf_q          <= '0;
      wdata_q        <= '0;
      err_on_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q    <= src_addr & WORD_MASK;
            dst_q    <= dst_addr & WORD_MASK;
            remain_q <= word_count;
          end
        end
        RD_D: begin
          if (bus.HREADY) begin
            if (bus.HRESP) begin
              err_on_write_q <= 1'b0;
            end else begin
              buf_q <= bus.HRDATA;
            end
          end
        end
        WR_A: begin
          // Loaded once as the write data phase begins so HWDATA is steady through wait states
          if (bus.HREADY) begin
            wdata_q <= buf_q;
          end
        end
        WR_D: begin
          if (bus.HREADY) begin
            if (bus.HRESP) begin
              err_on_write_q <= 1'b1;
            end else begin
              src_q    <= src_q + 32'd4;
              dst_q    <= dst_q + 32'd4;
              remain_q <= remain_q - LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Host status: busy from the cycle after start until the done/error pulse, which is registered
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_addr <= '0;
    end else begin
      done  <= (state_q == DONE);
      error <= (state_q == ERR);
      if (state_q == IDLE && start) begin
        busy <= 1'b1;
      end else if (state_q == DONE || state_q == ERR) begin
        busy <= 1'b0;
      end
      if (state_q == ERR) begin
        err_addr <= err_on_write_q ? dst_q : src_q;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_copy_master.sv
// tb/tb_ahb_lite_copy_master.sv - directed bench with bus-slave memory model and transfer scoreboard
module tb_ahb_lite_copy_master;

  logic        HCLK;
  logic        HRESETn;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] err_addr;

  ahb_lite_copy_master_if bus ();

  ahb_lite_copy_master #(.LEN_W(16)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_addr   (err_addr),
    .bus        (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] mem [logic [31:0]];
  xfer_t       exp_q [$];
  logic [31:0] rd_log [$];

  int          job_s = 1000000000;
  int          exp_pulse = -1;
  bit          exp_is_err = 1'b0;
  logic [31:0] exp_err_addr = '0;
  bit          pulse_seen = 1'b0;
  int          pulse_cyc = 0;
  bit          pulse_err = 1'b0;
  int          n_writes = 0;
  int          n_xfers = 0;

  int          cfg_waits = 0;
  bit          cfg_err_en = 1'b0;
  logic [31:0] cfg_err_addr = '0;
  bit          cfg_err_wr = 1'b0;

  bit          dp_active = 1'b0;
  logic [31:0] dp_addr = '0;
  bit          dp_wr = 1'b0;
  int          dp_wait = 0;
  bit          dp_err = 1'b0;
  bit          dp_err2 = 1'b0;
  logic [31:0] dp_data = '0;

  int          cur_n = 0;
  logic [31:0] cur_da = '0;
  logic [31:0] cur_seed = '0;
  int          exp_copied = 0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Slave model plus per-cycle comparison against the job-level expectations
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_active   = 1'b0;
      bus.HREADY  = 1'b1;
      bus.HRESP   = 1'b0;
      bus.HRDATA  = JUNK;
      check("rst_htrans", 32'(bus.HTRANS), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_error", 32'(error), 32'h0);
    end else begin
      check("busy", 32'(busy), 32'(cyc > job_s && cyc < exp_pulse));
      check("done", 32'(done), 32'(cyc == exp_pulse && !exp_is_err));
      check("error", 32'(error), 32'(cyc == exp_pulse && exp_is_err));
      if (!busy) check("idle_htrans", 32'(bus.HTRANS), 32'h0);
      if (done || error) begin
        pulse_seen = 1'b1;
        pulse_cyc  = cyc;
        pulse_err  = error;
      end
      if (dp_active) begin
        if (dp_wr) check("hwdata", bus.HWDATA, dp_data);
        if (dp_wait > 0) begin
          bus.HREADY = 1'b0;
          bus.HRESP  = 1'b0;
          bus.HRDATA = JUNK;
          dp_wait--;
        end else if (dp_err && !dp_err2) begin
          bus.HREADY = 1'b0;
          bus.HRESP  = 1'b1;
          bus.HRDATA = JUNK;
          dp_err2    = 1'b1;
        end else begin
          bus.HREADY = 1'b1;
          bus.HRESP  = dp_err;
          bus.HRDATA = (!dp_wr && !dp_err) ? mem_rd(dp_addr) : JUNK;
          if (dp_wr && !dp_err) mem[dp_addr] = bus.HWDATA;
          dp_active = 1'b0;
        end
      end else begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = JUNK;
      end
      if (bus.HTRANS == 2'b10 && bus.HREADY) begin
        n_xfers++;
        check("hsize", 32'(bus.HSIZE), 32'h2);
        check("hburst", 32'(bus.HBURST), 32'h0);
        check("hprot", 32'(bus.HPROT), 32'h3);
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", bus.HADDR, 32'hFFFF_FFFF);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          check("xfer_addr", bus.HADDR, e.addr);
          check("xfer_write", 32'(bus.HWRITE), 32'(e.wr));
          dp_data = e.data;
        end
        if (bus.HWRITE) n_writes++;
        else rd_log.push_back(bus.HADDR);
        dp_active = 1'b1;
        dp_addr   = bus.HADDR;
        dp_wr     = bus.HWRITE;
        dp_wait   = cfg_waits;
        dp_err    = cfg_err_en && bus.HADDR == cfg_err_addr && bus.HWRITE == cfg_err_wr;
        dp_err2   = 1'b0;
      end
    end
  end

  // Seed memory, pulse start and derive the job's transfers and pulse cycle from the copy rules
  task automatic start_job(input logic [31:0] s_in, input logic [31:0] d_in, input int n,
                           input int waits, input logic [31:0] seed,
                           input bit e_en, input logic [31:0] e_addr, input bit e_wr);
    logic [31:0] sa;
    logic [31:0] da;
    int          acc;
    int          s;
    bit          stop;
    sa = s_in & 32'hFFFF_FFFC;
    da = d_in & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      mem[sa + 32'(4 * i)] = seed + 32'(i);
      mem[da + 32'(4 * i)] = 32'hDEAD_0000 + 32'(i);
    end
    tick();
    start      = 1'b1;
    src_addr   = s_in;
    dst_addr   = d_in;
    word_count = 16'(n);
    s          = cyc;
    exp_q.delete();
    rd_log.delete();
    cfg_waits    = waits;
    cfg_err_en   = e_en;
    cfg_err_addr = e_addr;
    cfg_err_wr   = e_wr;
    pulse_seen   = 1'b0;
    n_writes     = 0;
    n_xfers      = 0;
    cur_n        = n;
    cur_da       = da;
    cur_seed     = seed;
    exp_is_err   = 1'b0;
    exp_copied   = n;
    acc          = 0;
    stop         = 1'b0;
    exp_pulse    = s + 2;
    for (int i = 0; i < n && !stop; i++) begin
      logic [31:0] ra;
      logic [31:0] wa;
      ra = sa + 32'(4 * i);
      wa = da + 32'(4 * i);
      exp_q.push_back('{addr: ra, wr: 1'b0, data: 32'h0});
      if (e_en && !e_wr && e_addr == ra) begin
        exp_pulse = s + acc + 2 + waits + 1 + 2;
        exp_is_err = 1'b1; exp_err_addr = ra; exp_copied = i; stop = 1'b1;
      end else begin
        exp_q.push_back('{addr: wa, wr: 1'b1, data: seed + 32'(i)});
        if (e_en && e_wr && e_addr == wa) begin
          exp_pulse = s + acc + 4 + 2 * waits + 1 + 2;
          exp_is_err = 1'b1; exp_err_addr = wa; exp_copied = i; stop = 1'b1;
        end else begin
          acc += 4 + 2 * waits;
          exp_pulse = s + acc + 2;
        end
      end
    end
    job_s = s;
    tick();
    start      = 1'b0;
    src_addr   = 32'h5555_5555;
    dst_addr   = 32'hAAAA_AAAA;
    word_count = 16'hFFFF;
  endtask

  task automatic finish_job(output int delta);
    for (int k = 0; k < 400 && !pulse_seen; k++) tick();
    check("pulse_seen", 32'(pulse_seen), 32'h1);
    delta = pulse_cyc - job_s;
    check("pulse_cycle", 32'(pulse_cyc), 32'(exp_pulse));
    check("pulse_kind", 32'(pulse_err), 32'(exp_is_err));
    if (exp_is_err) check("err_addr", err_addr, exp_err_addr);
    tick();
    check("busy_after", 32'(busy), 32'h0);
    check("xfers_left", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < cur_n; i++) begin
      check("dst_word", mem_rd(cur_da + 32'(4 * i)),
            (i < exp_copied) ? cur_seed + 32'(i) : 32'hDEAD_0000 + 32'(i));
    end
  endtask

  initial begin
    int d;
    HRESETn    = 1'b0;
    start      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    word_count = '0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = JUNK;
    repeat (3) tick();
    check("reset_haddr", bus.HADDR, 32'h0);
    check("reset_hwrite", 32'(bus.HWRITE), 32'h0);
    check("reset_hwdata", bus.HWDATA, 32'h0);
    check("reset_err_addr", err_addr, 32'h0);
    HRESETn = 1'b1;
    tick();

    // T1: four zero-wait words
    start_job(32'h100, 32'h200, 4, 0, 32'hA0, 1'b0, 32'h0, 1'b0);
    finish_job(d);
    check("t1_done_at", 32'(d), 32'd18);
    check("t1_writes", 32'(n_writes), 32'd4);
    check("t1_dst3", mem_rd(32'h20C), 32'hA3);

    // T2: one word, two wait states in each data phase
    start_job(32'h300, 32'h400, 1, 2, 32'h1122_3344, 1'b0, 32'h0, 1'b0);
    finish_job(d);
    check("t2_done_at", 32'(d), 32'd10);
    check("t2_dst0", mem_rd(32'h400), 32'h1122_3344);

    // T3: ERROR on the read of word 2, then ERROR on a write with wait states
    start_job(32'h100, 32'h500, 4, 0, 32'hB0, 1'b1, 32'h104, 1'b0);
    finish_job(d);
    check("t3_err_addr", err_addr, 32'h104);
    check("t3_writes", 32'(n_writes), 32'd1);
    check("t3_error_at", 32'(d), 32'd9);
    start_job(32'h100, 32'h600, 3, 1, 32'hC0, 1'b1, 32'h604, 1'b1);
    finish_job(d);
    check("t3b_err_addr", err_addr, 32'h604);

    // T4: zero-length job, err_addr holds, start ignored while busy
    start_job(32'h0, 32'h700, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
    finish_job(d);
    check("t4_done_at", 32'(d), 32'd2);
    check("t4_xfers", 32'(n_xfers), 32'd0);
    check("t4_err_hold", err_addr, 32'h604);
    start_job(32'h800, 32'h900, 3, 0, 32'hD0, 1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    start      = 1'b1;
    src_addr   = 32'h9000;
    word_count = 16'd7;
    tick();
    start = 1'b0;
    finish_job(d);
    check("t4b_done_at", 32'(d), 32'd14);

    // T5: address wrap and unaligned addresses
    start_job(32'hFFFF_FFFC, 32'h1000, 2, 0, 32'hE0, 1'b0, 32'h0, 1'b0);
    finish_job(d);
    check("t5_wrap_rd", rd_log[1], 32'h0);
    start_job(32'h103, 32'h1107, 1, 0, 32'hE8, 1'b0, 32'h0, 1'b0);
    finish_job(d);
    check("t5_unaligned_rd", rd_log[0], 32'h100);
    check("t5_unaligned_wr", mem_rd(32'h1104), 32'hE8);

    // T6: asynchronous reset during the first write address phase, then a clean job
    start_job(32'h2000, 32'h3000, 3, 0, 32'hF0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 20 && !(bus.HTRANS == 2'b10 && bus.HWRITE); k++) tick();
    check("t6_reached_wr_a", 32'(bus.HTRANS == 2'b10 && bus.HWRITE), 32'h1);
    HRESETn   = 1'b0;
    exp_q.delete();
    exp_pulse = -1;
    job_s     = 1000000000;
    #1;
    check("t6_async_htrans", 32'(bus.HTRANS), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
    start_job(32'h2000, 32'h3000, 3, 0, 32'hF8, 1'b0, 32'h0, 1'b0);
    finish_job(d);
    check("t6_done_at", 32'(d), 32'd14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
